// File: rtl/mem_router_pkg.sv
// Shared types and region map for the CPU-side memory router.
// Optional watchdog: MEM_ROUTER_TMO_EN.
package mem_router_pkg;

  localparam int MAX_NREG = 8;
  localparam int IW = $clog2(MAX_NREG);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } state_e;

  // Entries beyond the configured region count have size 0 and never hit.
  localparam logic [MAX_NREG-1:0][31:0] REGION_BASE = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0000_6000, 32'h0000_2000, 32'h0000_0000
  };

  localparam logic [MAX_NREG-1:0][31:0] REGION_SIZE = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0000_A000, 32'h0000_4000, 32'h0000_2000
  };

endpackage

// File: rtl/mem_router_dec.sv
// Address decoder: region hit, region index and region-relative word offset.
// Optional watchdog (top level only): MEM_ROUTER_TMO_EN.
module mem_router_dec
  import mem_router_pkg::*;
#(
  parameter int NREG = 3,
  parameter int AW   = 32
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic [AW-3:0] woff
);

  logic [63:0]   a64;
  logic [63:0]   lo;
  logic [63:0]   hi;
  logic [AW-1:0] off;

  // Scan high to low so the lowest hitting region is the one kept.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    off  = '0;
    a64  = 64'(addr);
    lo   = '0;
    hi   = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      lo = 64'(REGION_BASE[k]);
      hi = lo + 64'(REGION_SIZE[k]);
      if (a64 >= lo && a64 < hi) begin
        hit = 1'b1;
        idx = IW'(k);
        off = addr - AW'(REGION_BASE[k]);
      end
    end
    woff = (AW-2)'(off >> 2);
  end

endmodule

// File: rtl/mem_router.sv
// CPU data-port router: decode, latch, strobe one slave, stall the CPU.
// Optional watchdog: MEM_ROUTER_TMO_EN (timeout after TMO_CYC cycles).
module mem_router
  import mem_router_pkg::*;
#(
  parameter int NREG    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd,
  input  logic               wr,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      data_i,
  output logic [DW-1:0]      data_o,
  output logic               hold_cpu,
  output logic               bus_err,
  output logic [NREG-1:0]    slv_rd,
  output logic [NREG-1:0]    slv_wr,
  output logic [AW-3:0]      slv_addr_o,
  output logic [DW-1:0]      slv_data_o,
  input  logic [NREG-1:0]    slv_busy,
  input  logic [NREG-1:0]    slv_rvalid,
  input  logic [NREG*DW-1:0] slv_data_i
);

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic [AW-3:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
`ifdef MEM_ROUTER_TMO_EN
  logic [7:0]      cnt_q, cnt_d;
`endif

  logic            valid;
  logic            hit;
  logic [IW-1:0]   idx;
  logic [AW-3:0]   woff;
  logic [NREG-1:0] hit_oh;
  logic [DW-1:0]   rsel;
  logic            busy_s;
  logic            rvalid_s;

  assign valid = rd ^ wr;

  mem_router_dec #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .addr (addr_i),
    .hit  (hit),
    .idx  (idx),
    .woff (woff)
  );

  // One-hot region select and the read slice of the latched region.
  always_comb begin
    hit_oh = '0;
    rsel   = '0;
    for (int k = 0; k < NREG; k++) begin
      hit_oh[k] = (idx == IW'(k));
      if (sel_q[k]) rsel = slv_data_i[k*DW +: DW];
    end
  end

  assign busy_s   = |(slv_busy & sel_q);
  assign rvalid_s = |(slv_rvalid & sel_q);

  // Next-state logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (valid && hit) begin
          wr_d    = wr;
          sel_d   = hit_oh;
          addr_d  = woff;
          wdata_d = data_i;
          state_d = REQ;
        end else if (valid) begin
          rdata_d = '0;
          state_d = ERR;
        end
      end
      REQ: begin
        if (!busy_s) state_d = wr_q ? DONE : WAIT;
      end
      WAIT: begin
        if (rvalid_s) begin
          rdata_d = rsel;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MEM_ROUTER_TMO_EN
    cnt_d = '0;
    if ((state_q == REQ || state_q == WAIT) && state_d == state_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TMO_CYC)) begin
        cnt_d   = '0;
        rdata_d = '0;
        state_d = ERR;
      end
    end
`endif
  end

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ROUTER_TMO_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ROUTER_TMO_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign slv_rd     = (state_q == REQ && !wr_q) ? sel_q : '0;
  assign slv_wr     = (state_q == REQ &&  wr_q) ? sel_q : '0;
  assign slv_addr_o = addr_q;
  assign slv_data_o = wdata_q;
  assign data_o     = rdata_q;
  assign bus_err    = (state_q == ERR);
  assign hold_cpu   = (state_q == REQ) || (state_q == WAIT) ||
                      (state_q == IDLE && valid);

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router with a transaction-level expectation model.
// Define MEM_ROUTER_TMO_EN to also exercise the watchdog.
module tb_mem_router;

  localparam int NREG = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
`ifdef MEM_ROUTER_TMO_EN
  localparam int TMO   = 4;
  localparam int NBUSY = 2;
`else
  localparam int TMO   = 255;
  localparam int NBUSY = 4;
`endif

  localparam logic [31:0] SL [3] = '{32'h0BAD_0000, 32'h1BAD_1111, 32'h6008_BEEF};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [31:0]   addr_i = '0;
  logic [31:0]   data_i = '0;
  logic [31:0]   data_o;
  logic          hold_cpu;
  logic          bus_err;
  logic [2:0]    slv_rd;
  logic [2:0]    slv_wr;
  logic [29:0]   slv_addr_o;
  logic [31:0]   slv_data_o;
  logic [2:0]    slv_busy   = '0;
  logic [2:0]    slv_rvalid = '0;
  logic [95:0]   slv_data_i;

  always #5 clk = ~clk;

  mem_router #(
    .NREG    (NREG),
    .AW      (AW),
    .DW      (DW),
    .TMO_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .wr         (wr),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .hold_cpu   (hold_cpu),
    .bus_err    (bus_err),
    .slv_rd     (slv_rd),
    .slv_wr     (slv_wr),
    .slv_addr_o (slv_addr_o),
    .slv_data_o (slv_data_o),
    .slv_busy   (slv_busy),
    .slv_rvalid (slv_rvalid),
    .slv_data_i (slv_data_i)
  );

  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  logic        e_hold, e_err;
  logic [2:0]  e_rd, e_wr;
  logic [29:0] e_sa;
  logic [31:0] e_sd, e_data;
  logic [31:0] md = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Region map and address translation from the block's stated rules.
  function automatic void model_dec(input logic [31:0] a, output bit hit,
                                    output int k, output logic [29:0] off);
    logic [31:0] base [3];
    logic [31:0] size [3];
    base = '{32'h0, 32'h2000, 32'h6000};
    size = '{32'h2000, 32'h4000, 32'hA000};
    hit = 1'b0;
    k   = 0;
    off = '0;
    for (int i = 0; i < 3; i++) begin
      if (!hit && a >= base[i] && (a - base[i]) < size[i]) begin
        hit = 1'b1;
        k   = i;
        off = 30'((a - base[i]) >> 2);
      end
    end
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("hold_cpu", 64'(hold_cpu), 64'(e_hold));
      chk("bus_err",  64'(bus_err),  64'(e_err));
      chk("slv_rd",   64'(slv_rd),   64'(e_rd));
      chk("slv_wr",   64'(slv_wr),   64'(e_wr));
      chk("data_o",   64'(data_o),   64'(e_data));
      if (e_rd != 3'b0 || e_wr != 3'b0) begin
        chk("slv_addr_o", 64'(slv_addr_o), 64'(e_sa));
        chk("slv_data_o", 64'(slv_data_o), 64'(e_sd));
      end
    end
  end

  task automatic step(input logic s_rst, s_rd, s_wr,
                      input logic [31:0] a, d,
                      input logic [2:0] bsy, rv,
                      input logic h, er,
                      input logic [2:0] srd, swr,
                      input logic [29:0] sa,
                      input logic [31:0] sd, dexp);
    @(negedge clk);
    rst        = s_rst;
    rd         = s_rd;
    wr         = s_wr;
    addr_i     = a;
    data_i     = d;
    slv_busy   = bsy;
    slv_rvalid = rv;
    e_hold     = h;
    e_err      = er;
    e_rd       = srd;
    e_wr       = swr;
    e_sa       = sa;
    e_sd       = sd;
    e_data     = dexp;
    chk_en     = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, md);
  endtask

  // One CPU access: nb busy cycles on the slave, read data nw cycles after acceptance.
  task automatic txn(input logic r, w, input logic [31:0] a, d,
                     input int nb, input int nw);
    bit          hit;
    int          k;
    logic [29:0] off;
    logic [2:0]  oh;
    model_dec(a, hit, k, off);
    oh = hit ? 3'(1 << k) : 3'b0;
    if (r == w) begin
      step(0, r, w, a, d, 0, 0, 0, 0, 0, 0, 0, 0, md);
      idle();
      return;
    end
    step(0, r, w, a, d, 0, 0, 1, 0, 0, 0, 0, 0, md);
    if (!hit) begin
      md = '0;
      step(0, r, w, a, d, 0, 0, 0, 1, 0, 0, 0, 0, md);
      idle();
      return;
    end
    for (int i = 0; i <= nb; i++)
      step(0, r, w, a, d, (i < nb) ? oh : 3'b0, 0, 1, 0,
           r ? oh : 3'b0, w ? oh : 3'b0, off, d, md);
    if (r) begin
      for (int i = 1; i <= nw; i++)
        step(0, r, w, a, d, 0, (i == nw) ? oh : ~oh, 1, 0, 0, 0, 0, 0, md);
      md = SL[k];
    end
    step(0, r, w, a, d, 0, 0, 0, 0, 0, 0, 0, 0, md);
    idle();
  endtask

  initial begin
    bit          hit;
    int          k;
    logic [29:0] off;
    slv_data_i = {SL[2], SL[1], SL[0]};

    model_dec(32'h2004, hit, k, off);
    chk("dec_2004_k", 64'(k), 64'd1);
    chk("dec_2004_off", 64'(off), 64'd1);
    model_dec(32'h6008, hit, k, off);
    chk("dec_6008_k", 64'(k), 64'd2);
    chk("dec_6008_off", 64'(off), 64'd2);
    model_dec(32'h10000, hit, k, off);
    chk("dec_10000_hit", 64'(hit), 64'd0);
    model_dec(32'h1FFF, hit, k, off);
    chk("dec_1fff_off", 64'(off), 64'h7FF);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, md);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, md);
    idle();

    txn(0, 1, 32'h2004, 32'hCAFE_0001, 0, 0);
    txn(1, 0, 32'h6008, 32'h0, 0, 3);
    #3 chk("rd_6008_lit", 64'(data_o), 64'h6008_BEEF);
    txn(0, 1, 32'h0010, 32'h1234_5678, NBUSY, 0);
    txn(1, 0, 32'h10000, 32'h0, 0, 0);
    #3 chk("miss_data_lit", 64'(data_o), 64'h0);
    txn(1, 1, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 32'h2010, 32'h0, 1, 1);

    step(0, 1, 0, 32'h6008, 0, 0, 0, 1, 0, 0, 0, 0, 0, md);
    step(0, 1, 0, 32'h6008, 0, 0, 0, 1, 0, 3'b100, 0, 30'd2, 0, md);
    step(0, 1, 0, 32'h6008, 0, 0, 0, 1, 0, 0, 0, 0, 0, md);
    md = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, md);
    step(0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, md);
    idle();

`ifdef MEM_ROUTER_TMO_EN
    txn(1, 0, 32'h2000, 32'h0, 0, 1);
    step(0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, md);
    step(0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 3'b001, 0, 30'd0, 0, md);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, md);
    md = '0;
    step(0, 1, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0, md);
    idle();
`endif

    idle();
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
